// File: rtl/fft_pkg.sv
// Shared definitions for the FFT butterfly datapath: default widths, the unity
// twiddle constant, complex-multiply sequencer states and product indices.
package fft_pkg;

    localparam int CM_DW        = 16;
    localparam int CM_FRAC_BITS = 14;
    localparam int TW_ONE       = 1 << CM_FRAC_BITS;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_FIN,
        ST_OUT
    } cmult_state_e;

    // Issue order of the four partial products of (ar + j*ai)*(wr + j*wi)
    localparam logic [1:0] IDX_RR = 2'd0;
    localparam logic [1:0] IDX_II = 2'd1;
    localparam logic [1:0] IDX_RI = 2'd2;
    localparam logic [1:0] IDX_IR = 2'd3;

endpackage

// File: rtl/cmult_sat_round.sv
// Rescales a Q(FRAC_BITS) accumulator by an arithmetic (flooring) right shift
// and saturates the result into a signed DW-bit word, flagging any clipping.
module cmult_sat_round #(
    parameter int DW        = 16,
    parameter int FRAC_BITS = 14,
    parameter int AW        = 2 * DW + 1
) (
    input  logic signed [AW-1:0] acc,
    output logic signed [DW-1:0] y,
    output logic                 sat
);

    localparam logic signed [AW-1:0] MAX_V = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [AW-1:0] MIN_V = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    logic signed [AW-1:0] shifted;

    always_comb begin
        shifted = acc >>> FRAC_BITS;
        y       = shifted[DW-1:0];
        sat     = 1'b0;
        if (shifted > MAX_V) begin
            y   = MAX_V[DW-1:0];
            sat = 1'b1;
        end else if (shifted < MIN_V) begin
            y   = MIN_V[DW-1:0];
            sat = 1'b1;
        end
    end

endmodule

// File: rtl/cmult_seq.sv
// Complex-multiply sequencer: feeds four real products through one shared serial
// multiplier, accumulates re/im, rescales, saturates and hands off the result.
module cmult_seq
    import fft_pkg::*;
#(
    parameter int DW        = CM_DW,
    parameter int FRAC_BITS = CM_FRAC_BITS,
    parameter int BYPASS_W0 = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic signed [DW-1:0]   ar,
    input  logic signed [DW-1:0]   ai,
    input  logic signed [DW-1:0]   wr,
    input  logic signed [DW-1:0]   wi,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic signed [DW-1:0]   yr,
    output logic signed [DW-1:0]   yi,
    output logic                   out_sat,
    output logic signed [DW-1:0]   mul_a,
    output logic signed [DW-1:0]   mul_b,
    output logic                   mul_start,
    input  logic signed [2*DW-1:0] mul_p,
    input  logic                   mul_done
);

    localparam int AW = 2 * DW + 1;
    localparam logic [DW-1:0] W_ONE = {{(DW-1){1'b0}}, 1'b1} << FRAC_BITS;

    cmult_state_e state, state_next;

    logic        [1:0]    idx;
    logic        [1:0]    idx_next;
    logic signed [DW-1:0] ar_q, ai_q, wr_q, wi_q;
    logic signed [DW-1:0] next_a, next_b;
    logic signed [AW-1:0] acc_re, acc_im;
    logic signed [AW-1:0] p_ext;
    logic signed [DW-1:0] sat_re, sat_im;
    logic                 sat_re_flag, sat_im_flag;
    logic                 accept;
    logic                 bypass_hit;

    assign accept     = in_valid && (state == ST_IDLE);
    assign bypass_hit = (BYPASS_W0 != 0) && (wr == W_ONE) && (wi == '0);
    assign p_ext      = {mul_p[2*DW-1], mul_p};
    assign idx_next   = idx + 2'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        mul_start  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = bypass_hit ? ST_OUT : ST_ISSUE;
            end
            ST_ISSUE: begin
                mul_start  = 1'b1;
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (mul_done) state_next = (idx == IDX_IR) ? ST_FIN : ST_ISSUE;
            end
            ST_FIN: state_next = ST_OUT;
            ST_OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Operands for the product that follows the one just completed
    always_comb begin
        next_a = ar_q;
        next_b = wr_q;
        unique case (idx_next)
            IDX_II:  begin next_a = ai_q; next_b = wi_q; end
            IDX_RI:  begin next_a = ar_q; next_b = wi_q; end
            IDX_IR:  begin next_a = ai_q; next_b = wr_q; end
            default: begin next_a = ar_q; next_b = wr_q; end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx     <= IDX_RR;
            ar_q    <= '0;
            ai_q    <= '0;
            wr_q    <= '0;
            wi_q    <= '0;
            acc_re  <= '0;
            acc_im  <= '0;
            mul_a   <= '0;
            mul_b   <= '0;
            yr      <= '0;
            yi      <= '0;
            out_sat <= 1'b0;
        end else if (accept) begin
            ar_q   <= ar;
            ai_q   <= ai;
            wr_q   <= wr;
            wi_q   <= wi;
            acc_re <= '0;
            acc_im <= '0;
            idx    <= IDX_RR;
            mul_a  <= ar;
            mul_b  <= wr;
            if (bypass_hit) begin
                yr      <= ar;
                yi      <= ai;
                out_sat <= 1'b0;
            end
        end else if (state == ST_WAIT && mul_done) begin
            unique case (idx)
                IDX_RR:  acc_re <= acc_re + p_ext;
                IDX_II:  acc_re <= acc_re - p_ext;
                default: acc_im <= acc_im + p_ext;
            endcase
            if (idx != IDX_IR) begin
                idx   <= idx_next;
                mul_a <= next_a;
                mul_b <= next_b;
            end
        end else if (state == ST_FIN) begin
            yr      <= sat_re;
            yi      <= sat_im;
            out_sat <= sat_re_flag | sat_im_flag;
        end
    end

    cmult_sat_round #(.DW(DW), .FRAC_BITS(FRAC_BITS), .AW(AW)) u_sat_re (
        .acc (acc_re),
        .y   (sat_re),
        .sat (sat_re_flag)
    );

    cmult_sat_round #(.DW(DW), .FRAC_BITS(FRAC_BITS), .AW(AW)) u_sat_im (
        .acc (acc_im),
        .y   (sat_im),
        .sat (sat_im_flag)
    );

endmodule

// File: tb/tb_cmult_seq.sv
// Directed bench for cmult_seq: one bypass-enabled and one bypass-disabled
// instance, each served by a fixed-latency shared-multiplier model.
module tb_cmult_seq;
    import fft_pkg::*;

    localparam int DW = 16;
    localparam int L  = 17;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic                   in_valid  [2];
    logic                   in_ready  [2];
    logic                   out_valid [2];
    logic                   out_ready [2];
    logic                   out_sat   [2];
    logic                   mul_start [2];
    logic                   mul_done  [2];
    logic                   done_m    [2] = '{1'b0, 1'b0};
    logic                   stray     [2];
    logic signed [DW-1:0]   yr        [2];
    logic signed [DW-1:0]   yi        [2];
    logic signed [DW-1:0]   mul_a     [2];
    logic signed [DW-1:0]   mul_b     [2];
    logic signed [2*DW-1:0] prod      [2] = '{'0, '0};
    int                     cnt       [2] = '{0, 0};
    int                     start_total [2] = '{0, 0};
    logic signed [DW-1:0]   ar, ai, wr, wi;

    int checks   = 0;
    int failures = 0;

    assign mul_done[0] = done_m[0] | stray[0];
    assign mul_done[1] = done_m[1] | stray[1];

    cmult_seq #(.DW(DW), .FRAC_BITS(14), .BYPASS_W0(1)) u_byp (
        .clk(clk), .reset(reset),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .ar(ar), .ai(ai), .wr(wr), .wi(wi),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .yr(yr[0]), .yi(yi[0]), .out_sat(out_sat[0]),
        .mul_a(mul_a[0]), .mul_b(mul_b[0]), .mul_start(mul_start[0]),
        .mul_p(prod[0]), .mul_done(mul_done[0])
    );

    cmult_seq #(.DW(DW), .FRAC_BITS(14), .BYPASS_W0(0)) u_full (
        .clk(clk), .reset(reset),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .ar(ar), .ai(ai), .wr(wr), .wi(wi),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .yr(yr[1]), .yi(yi[1]), .out_sat(out_sat[1]),
        .mul_a(mul_a[1]), .mul_b(mul_b[1]), .mul_start(mul_start[1]),
        .mul_p(prod[1]), .mul_done(mul_done[1])
    );

    // Multiplier model: done pulses L cycles after the start cycle; not reset with the DUT
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            done_m[k] <= 1'b0;
            if (mul_start[k]) begin
                cnt[k]         <= L - 1;
                prod[k]        <= mul_a[k] * mul_b[k];
                start_total[k] <= start_total[k] + 1;
            end else if (cnt[k] != 0) begin
                cnt[k] <= cnt[k] - 1;
                if (cnt[k] == 1) done_m[k] <= 1'b1;
            end
        end
    end

    task automatic checkOutput(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input int sel, input logic signed [DW-1:0] a_r,
                                 input logic signed [DW-1:0] a_i,
                                 input logic signed [DW-1:0] w_r,
                                 input logic signed [DW-1:0] w_i);
        ar            = a_r;
        ai            = a_i;
        wr            = w_r;
        wi            = w_i;
        in_valid[sel] = 1'b1;
        @(posedge clk); #1;
        in_valid[sel] = 1'b0;
    endtask

    task automatic waitResult(input int sel, input string tag, output int cycles);
        cycles = 1;
        while (!out_valid[sel] && cycles < 400) begin
            @(posedge clk); #1;
            cycles++;
        end
        checkOutput({tag, "_valid"}, longint'(out_valid[sel]), 1);
    endtask

    task automatic checkResult(input int sel, input string tag, input longint eyr,
                               input longint eyi, input longint esat);
        checkOutput({tag, "_yr"}, longint'(yr[sel]), eyr);
        checkOutput({tag, "_yi"}, longint'(yi[sel]), eyi);
        checkOutput({tag, "_sat"}, longint'(out_sat[sel]), esat);
    endtask

    task automatic stepCycle();
        @(posedge clk); #1;
    endtask

    initial begin
        int cyc;
        int s0;
        logic seen;
        for (int k = 0; k < 2; k++) begin
            in_valid[k]  = 1'b0;
            out_ready[k] = 1'b1;
            stray[k]     = 1'b0;
        end
        ar = '0; ai = '0; wr = '0; wi = '0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_in_ready", longint'(in_ready[1]), 1);
        checkOutput("rst_out_valid", longint'(out_valid[1]), 0);
        checkOutput("rst_mul_start", longint'(mul_start[1]), 0);
        checkOutput("rst_yr", longint'(yr[1]), 0);
        checkOutput("rst_mul_a", longint'(mul_a[1]), 0);
        checkOutput("rst_out_sat", longint'(out_sat[0]), 0);
        reset = 1'b0;
        stepCycle();

        s0 = start_total[1];
        applyStimulus(1, 16'sd1000, 16'sd2000, 16'sd11585, -16'sd11585);
        waitResult(1, "nom", cyc);
        checkOutput("nom_latency", cyc, 74);
        checkResult(1, "nom", 2121, 707, 0);
        checkOutput("nom_starts", start_total[1] - s0, 4);
        stepCycle();

        applyStimulus(1, 16'sd32767, -16'sd32768, 16'sd16383, 16'sd16383);
        waitResult(1, "sat", cyc);
        checkResult(1, "sat", 32767, -1, 1);
        stepCycle();

        s0 = start_total[0];
        applyStimulus(0, -16'sd5, 16'sd7, 16'(TW_ONE), 16'sd0);
        waitResult(0, "byp", cyc);
        checkOutput("byp_latency", cyc, 1);
        checkResult(0, "byp", -5, 7, 0);
        checkOutput("byp_starts", start_total[0] - s0, 0);
        stepCycle();

        s0 = start_total[1];
        applyStimulus(1, -16'sd5, 16'sd7, 16'(TW_ONE), 16'sd0);
        waitResult(1, "nobyp", cyc);
        checkOutput("nobyp_latency", cyc, 74);
        checkResult(1, "nobyp", -5, 7, 0);
        checkOutput("nobyp_starts", start_total[1] - s0, 4);
        stepCycle();

        out_ready[1] = 1'b0;
        applyStimulus(1, 16'sd1000, 16'sd2000, 16'sd11585, -16'sd11585);
        waitResult(1, "bp", cyc);
        checkOutput("bp_latency", cyc, 74);
        s0 = start_total[1];
        for (int i = 0; i < 10; i++) begin
            ar = 16'sd1; ai = 16'sd1; wr = 16'sd3; wi = 16'sd3;
            in_valid[1] = 1'b1;
            stepCycle();
            checkOutput("bp_hold_yr", longint'(yr[1]), 2121);
            checkOutput("bp_hold_yi", longint'(yi[1]), 707);
            checkOutput("bp_in_ready", longint'(in_ready[1]), 0);
            checkOutput("bp_out_valid", longint'(out_valid[1]), 1);
        end
        in_valid[1]  = 1'b0;
        out_ready[1] = 1'b1;
        stepCycle();
        checkOutput("bp_rel_valid", longint'(out_valid[1]), 0);
        checkOutput("bp_rel_ready", longint'(in_ready[1]), 1);
        stepCycle();
        checkOutput("bp_ignored_starts", start_total[1] - s0, 0);
        checkOutput("bp_ignored_valid", longint'(out_valid[1]), 0);

        applyStimulus(1, 16'sd1000, 16'sd2000, 16'sd11585, -16'sd11585);
        repeat (44) stepCycle();
        reset = 1'b1;
        #1;
        checkOutput("mid_rst_in_ready", longint'(in_ready[1]), 1);
        checkOutput("mid_rst_valid", longint'(out_valid[1]), 0);
        checkOutput("mid_rst_mul_a", longint'(mul_a[1]), 0);
        checkOutput("mid_rst_mul_b", longint'(mul_b[1]), 0);
        checkOutput("mid_rst_yr", longint'(yr[1]), 0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            stepCycle();
            seen = seen | out_valid[1] | mul_start[1];
        end
        checkOutput("post_rst_quiet", longint'(seen), 0);
        applyStimulus(1, 16'sd1000, 16'sd2000, 16'sd11585, -16'sd11585);
        waitResult(1, "post_rst", cyc);
        checkOutput("post_rst_latency", cyc, 74);
        checkResult(1, "post_rst", 2121, 707, 0);
        stepCycle();

        stray[1] = 1'b1;
        stepCycle();
        stray[1] = 1'b0;
        stepCycle();
        out_ready[1] = 1'b0;
        s0 = start_total[1];
        applyStimulus(1, 16'sd1000, 16'sd2000, 16'sd11585, -16'sd11585);
        waitResult(1, "spur", cyc);
        checkOutput("spur_latency", cyc, 74);
        stray[1] = 1'b1;
        stepCycle();
        stray[1] = 1'b0;
        stepCycle();
        checkResult(1, "spur", 2121, 707, 0);
        checkOutput("spur_starts", start_total[1] - s0, 4);
        out_ready[1] = 1'b1;
        stepCycle();
        checkOutput("spur_done_valid", longint'(out_valid[1]), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
